// File: rtl/req_ack_sync_fifo.sv
// rtl/req_ack_sync_fifo.sv - single-clock FIFO, slave of push/pop req/ack handshakes
// Stream mode gives combinational acks; handshake mode runs an IDLE/ACK FSM per side.
module req_ack_sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stream_mode,
  input  logic              push_req,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ack,
  output logic              push_ack_pulse,
  output logic              push_full,
  input  logic              pop_req,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_ack,
  output logic              pop_ack_pulse,
  output logic              pop_empty,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t              push_st_q, push_st_d, pop_st_q, pop_st_d;
  logic                push_pulse_q, push_pulse_d, pop_pulse_q, pop_pulse_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                full, empty, wr_en, rd_en, s_push_ack, s_pop_ack;

  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    empty        = (count_q == '0);
    s_push_ack   = stream_mode & push_req & ~full;
    s_pop_ack    = stream_mode & pop_req & ~empty;
    wr_en        = s_push_ack;
    rd_en        = s_pop_ack;
    push_st_d    = push_st_q;
    pop_st_d     = pop_st_q;
    push_pulse_d = 1'b0;
    pop_pulse_d  = 1'b0;
    pop_data_d   = pop_data_q;

    // Stream mode parks both FSMs, which also aborts a handshake caught by a mode change.
    if (stream_mode) begin
      push_st_d = IDLE;
      pop_st_d  = IDLE;
    end else begin
      case (push_st_q)
        IDLE: if (push_req && !full) begin
          wr_en        = 1'b1;
          push_st_d    = ACK;
          push_pulse_d = 1'b1;
        end
        ACK:  if (!push_req) push_st_d = IDLE;
        default: push_st_d = IDLE;
      endcase
      case (pop_st_q)
        IDLE: if (pop_req && !empty) begin
          rd_en       = 1'b1;
          pop_data_d  = mem[rd_ptr_q];
          pop_st_d    = ACK;
          pop_pulse_d = 1'b1;
        end
        ACK:  if (!pop_req) pop_st_d = IDLE;
        default: pop_st_d = IDLE;
      endcase
    end

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_st_q    <= IDLE;
      pop_st_q     <= IDLE;
      push_pulse_q <= 1'b0;
      pop_pulse_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pop_data_q   <= '0;
    end else begin
      push_st_q    <= push_st_d;
      pop_st_q     <= pop_st_d;
      push_pulse_q <= push_pulse_d;
      pop_pulse_q  <= pop_pulse_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pop_data_q   <= pop_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_data;
  end

  // Stream acks are combinational, so rst masks them to drop without a clock edge.
  assign push_ack       = ~rst & (stream_mode ? s_push_ack : (push_st_q == ACK));
  assign push_ack_pulse = ~rst & (stream_mode ? s_push_ack : push_pulse_q);
  assign pop_ack        = ~rst & (stream_mode ? s_pop_ack : (pop_st_q == ACK));
  assign pop_ack_pulse  = ~rst & (stream_mode ? s_pop_ack : pop_pulse_q);
  assign pop_data       = rst ? '0 : (stream_mode ? mem[rd_ptr_q] : pop_data_q);
  assign push_full      = full;
  assign pop_empty      = empty;
  assign count          = count_q;

endmodule

// File: tb/tb_req_ack_sync_fifo.sv
// tb/tb_req_ack_sync_fifo.sv - randomized and directed bench for req_ack_sync_fifo
// Expected behaviour comes from a queue-based model of the push/pop rules.
module tb_req_ack_sync_fifo;
  localparam int DW = 64;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stream_mode = 1'b1;
  logic          push_req = 1'b1;
  logic          pop_req = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          push_ack, push_ack_pulse, push_full;
  logic          pop_ack, pop_ack_pulse, pop_empty;
  logic [DW-1:0] pop_data;
  logic [CW-1:0] count;

  req_ack_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stream_mode(stream_mode),
    .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
    .push_ack_pulse(push_ack_pulse), .push_full(push_full),
    .pop_req(pop_req), .pop_data(pop_data), .pop_ack(pop_ack),
    .pop_ack_pulse(pop_ack_pulse), .pop_empty(pop_empty), .count(count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] obs[$];
  logic          m_pack = 1'b0, m_ppulse = 1'b0, m_qack = 1'b0, m_qpulse = 1'b0;
  logic [DW-1:0] m_qword = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pack = 1'b0; m_ppulse = 1'b0; m_qack = 1'b0; m_qpulse = 1'b0; m_qword = '0;
  endtask

  // Entered at posedge+1: drive, check at negedge, advance the model at posedge.
  task automatic cycle(input logic pr, input logic [DW-1:0] pd, input logic qr);
    logic pa, pp, qa, qp, dp, dq;
    int   n;
    push_req = pr; push_data = pd; pop_req = qr;
    @(negedge clk);
    n = q.size();
    if (stream_mode) begin
      pa = pr && (n < DEPTH); qa = qr && (n > 0); pp = pa; qp = qa;
    end else begin
      pa = m_pack; pp = m_ppulse; qa = m_qack; qp = m_qpulse;
    end
    chk("push_ack", 64'(push_ack), 64'(pa));
    chk("push_ack_pulse", 64'(push_ack_pulse), 64'(pp));
    chk("pop_ack", 64'(pop_ack), 64'(qa));
    chk("pop_ack_pulse", 64'(pop_ack_pulse), 64'(qp));
    chk("count", 64'(count), 64'(n));
    chk("push_full", 64'(push_full), 64'(n == DEPTH));
    chk("pop_empty", 64'(pop_empty), 64'(n == 0));
    if (qa) chk("pop_data", pop_data, stream_mode ? q[0] : m_qword);
    if (qp) obs.push_back(pop_data);
    @(posedge clk);
    if (stream_mode) begin
      dp = pr && (n < DEPTH); dq = qr && (n > 0);
    end else begin
      dp = 1'b0; dq = 1'b0; m_ppulse = 1'b0; m_qpulse = 1'b0;
      if (m_pack) begin
        if (!pr) m_pack = 1'b0;
      end else if (pr && n < DEPTH) begin
        dp = 1'b1; m_pack = 1'b1; m_ppulse = 1'b1;
      end
      if (m_qack) begin
        if (!qr) m_qack = 1'b0;
      end else if (qr && n > 0) begin
        dq = 1'b1; m_qack = 1'b1; m_qpulse = 1'b1; m_qword = q[0];
      end
    end
    if (dq) void'(q.pop_front());
    if (dp) q.push_back(pd);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, '0, 1'b0);
  endtask

  task automatic hs_push(input logic [DW-1:0] d);
    int n = 0;
    while (!m_pack && n < 20) begin
      cycle(1'b1, d, 1'b0);
      n++;
    end
    chk("push_latency", 64'(n), 64'(1));
    idle(1);
  endtask

  task automatic hs_pop();
    int n = 0;
    while (!m_qack && n < 20) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    chk("pop_latency", 64'(n), 64'(1));
    idle(1);
  endtask

  task automatic chk_obs(input string tag, input int idx, input logic [DW-1:0] exp);
    logic [DW-1:0] got;
    got = (idx < obs.size()) ? obs[idx] : '1;
    chk(tag, got, exp);
  endtask

  initial begin
    // Reset held with push_req high in stream mode: combinational acks must stay low.
    repeat (3) begin
      @(negedge clk);
      chk("rst_push_ack", 64'(push_ack), 64'(0));
      chk("rst_pop_ack", 64'(pop_ack), 64'(0));
      chk("rst_push_pulse", 64'(push_ack_pulse), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_empty", 64'(pop_empty), 64'(1));
      chk("rst_full", 64'(push_full), 64'(0));
      chk("rst_pop_data", pop_data, 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0; push_req = 1'b0; stream_mode = 1'b0;
    model_reset();

    // Handshake mode, three words in order.
    idle(1);
    obs.delete();
    hs_push(64'hA1); hs_push(64'hA2); hs_push(64'hA3);
    repeat (3) hs_pop();
    chk("t2_npop", 64'(obs.size()), 64'(3));
    for (int i = 0; i < 3; i++) chk_obs("t2_data", i, 64'hA1 + 64'(i));
    chk("t2_count", 64'(count), 64'(0));

    // Stream mode overfill.
    stream_mode = 1'b1;
    for (int i = 0; i < 18; i++) cycle(1'b1, 64'(100 + i), 1'b0);
    chk("t3_count", 64'(count), 64'(16));
    chk("t3_full", 64'(push_full), 64'(1));
    obs.delete();
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) chk_obs("t3_data", i, 64'(100 + i));

    // Stream mode simultaneous push/pop at count 8.
    for (int i = 0; i < 8; i++) cycle(1'b1, 64'(200 + i), 1'b0);
    obs.delete();
    for (int i = 0; i < 20; i++) cycle(1'b1, 64'(300 + i), 1'b1);
    chk("t4_count", 64'(count), 64'(8));
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 28; i++) chk_obs("t4_data", i, (i < 8) ? 64'(200 + i) : 64'(300 + i - 8));

    // Handshake mode, 40 words through the ring.
    stream_mode = 1'b0;
    idle(1);
    obs.delete();
    for (int i = 0; i < 40; i++) begin
      hs_push(64'(i));
      hs_pop();
    end
    for (int i = 0; i < 40; i++) chk_obs("t5_data", i, 64'(i));

    // Random traffic, alternating modes; mode only changes with all acks idle.
    for (int ph = 0; ph < 4; ph++) begin
      stream_mode = ph[0];
      for (int i = 0; i < 250; i++) begin
        if (stream_mode)
          cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        else
          cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      end
      idle(2);
      stream_mode = 1'b1;
      for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
      chk("rand_drained", 64'(count), 64'(0));
    end

    // Asynchronous reset mid-burst at count 5.
    stream_mode = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'(500 + i), 1'b0);
    push_req = 1'b1; pop_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t6_push_ack", 64'(push_ack), 64'(0));
    chk("t6_pop_ack", 64'(pop_ack), 64'(0));
    chk("t6_count", 64'(count), 64'(0));
    chk("t6_empty", 64'(pop_empty), 64'(1));
    model_reset();
    @(posedge clk); #1;
    push_req = 1'b0; pop_req = 1'b0; rst = 1'b0;
    obs.delete();
    cycle(1'b1, 64'h66, 1'b0);
    cycle(1'b0, '0, 1'b1);
    chk("t6_npop", 64'(obs.size()), 64'(1));
    chk_obs("t6_data", 0, 64'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
